model_result_collector: RTL and testbench

- Downstream stage of a `model` instance. Captures the `o0` bus (range [2:-2]) and the `o1` bus (range [-2:2]) whenever the producer marks them valid.
- Packs each capture into one 10-bit word and buffers it in a DEPTH-entry FIFO. Hands words to the consumer over a valid/ready interface.
- Keeps a sticky overflow flag and a saturating count of captures whose `o0` equals a fixed pattern.

---
 rtl/model_result_collector.sv | 104 ++++++++++
 tb/tb_model_result_collector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/model_result_collector.sv
// Collects model o0/o1 result captures into a DEPTH-entry show-ahead FIFO of packed 10-bit words,
// tracking a sticky overflow flag and a saturating count of captures whose o0 matches PATTERN.
module model_result_collector #(
    parameter int         DEPTH   = 4,
    parameter string      SWAP    = "FALSE",
    parameter logic [4:0] PATTERN = 5'h13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:-2]              o0,
    input  logic [-2:2]              o1,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [9:0]               out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               match_count
);

    localparam int AW          = $clog2(DEPTH);
    localparam int LW          = AW + 1;
    localparam bit SWAP_HALVES = (SWAP == "TRUE");

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    match_q, match_d;

    logic [4:0]    o0_packed, o1_packed;
    logic [9:0]    word;
    logic          full, empty, push, pop, hit;

    // Vector assignment is positional, so the declared-left bit becomes the MSB for either range direction.
    assign o0_packed = o0;
    assign o1_packed = o1;
    assign word      = SWAP_HALVES ? {o1_packed, o0_packed} : {o0_packed, o1_packed};

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;
    assign hit   = (o0_packed == PATTERN);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        match_d    = match_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (in_valid && full)               overflow_d = 1'b1;
        if (push && hit && match_q != 8'hFF) match_d  = match_q + 1'b1;

        if (clear) begin
            overflow_d = 1'b0;
            match_d    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            match_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            match_q    <= match_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by level, and out_data is masked below.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= word;
    end

    assign out_data    = empty ? 10'd0 : mem_q[rd_ptr_q];
    assign out_valid   = !empty;
    assign in_ready    = !full;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign match_count = match_q;

endmodule

// File: tb/tb_model_result_collector.sv
// Directed self-checking bench for model_result_collector (DEPTH=4), with a second SWAP="TRUE" instance.
module tb_model_result_collector;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, clear, out_ready;
    logic [2:-2] o0;
    logic [-2:2] o1;

    logic       in_ready, out_valid, overflow;
    logic [9:0] out_data;
    logic [2:0] level;
    logic [7:0] match_count;

    logic       s_in_ready, s_out_valid, s_overflow;
    logic [9:0] s_out_data;
    logic [2:0] s_level;
    logic [7:0] s_match_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    model_result_collector #(.DEPTH(4), .SWAP("FALSE"), .PATTERN(5'h13)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .o0(o0), .o1(o1), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .level(level), .overflow(overflow), .match_count(match_count)
    );

    model_result_collector #(.DEPTH(4), .SWAP("TRUE"), .PATTERN(5'h13)) dut_swap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .o0(o0), .o1(o1), .clear(clear), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .level(s_level), .overflow(s_overflow), .match_count(s_match_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        o0 = '0; o1 = '0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_level",     32'(level),       32'd0);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_data",  32'(out_data),    32'd0);
        check("rst_overflow",  32'(overflow),    32'd0);
        check("rst_match",     32'(match_count), 32'd0);

        // Single capture, o0=13 o1=05.
        in_valid = 1'b1; o0 = 5'h13; o1 = 5'h05;
        check("no_bypass_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("push1_valid",     32'(out_valid),   32'd1);
        check("push1_data",      32'(out_data),    32'h265);
        check("push1_swap_data", 32'(s_out_data),  32'h0B3);
        check("push1_level",     32'(level),       32'd1);
        check("push1_match",     32'(match_count), 32'd1);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop1_valid", 32'(out_valid), 32'd0);
        check("pop1_level", 32'(level),     32'd0);
        check("pop1_data",  32'(out_data),  32'd0);

        // Five pushes with consumer stalled: words {i, 16+i} for i=1..5.
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; o0 = 5'(i); o1 = 5'(16 + i);
            tick();
            if (i == 4) begin
                check("fill_level4",    32'(level),    32'd4);
                check("fill_in_ready4", 32'(in_ready), 32'd0);
                check("fill_overflow4", 32'(overflow), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("drop_level",    32'(level),       32'd4);
        check("drop_overflow", 32'(overflow),    32'd1);
        check("drop_match",    32'(match_count), 32'd1);
        check("stall_head",    32'(out_data),    32'h031);
        tick();
        check("stall_head_stable", 32'(out_data),  32'h031);
        check("stall_valid",       32'(out_valid), 32'd1);

        // Full: push of a matching o0 with simultaneous pop -> pop only, push dropped and not counted.
        in_valid = 1'b1; out_ready = 1'b1; o0 = 5'h13; o1 = 5'h1F;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("full_pp_level",    32'(level),       32'd3);
        check("full_pp_overflow", 32'(overflow),    32'd1);
        check("full_pp_match",    32'(match_count), 32'd1);
        check("full_pp_head",     32'(out_data),    32'h052);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_overflow", 32'(overflow),    32'd0);
        check("clear_match",    32'(match_count), 32'd0);
        check("clear_level",    32'(level),       32'd3);

        // Drain words 2..4 in order.
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("drain_word%0d", i), 32'(out_data), 32'({5'(i), 5'(16 + i)}));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("drain_level", 32'(level),     32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Pop on empty is ignored.
        out_ready = 1'b1;
        tick();
        check("empty_pop_level", 32'(level),     32'd0);
        check("empty_pop_valid", 32'(out_valid), 32'd0);

        // Streaming: push w0 into empty FIFO, then push w_k / pop w_{k-1} for 10 cycles.
        in_valid = 1'b1; o0 = 5'd1; o1 = 5'd31;
        tick();
        check("stream_first_level", 32'(level),    32'd1);
        check("stream_first_data",  32'(out_data), 32'({5'd1, 5'd31}));
        for (int k = 1; k <= 10; k++) begin
            o0 = 5'(3 * k + 1); o1 = 5'(31 - k);
            tick();
            check($sformatf("stream_level%0d", k), 32'(level),    32'd1);
            check($sformatf("stream_data%0d", k),  32'(out_data), 32'({5'(3 * k + 1), 5'(31 - k)}));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_level", 32'(level), 32'd0);

        // 300 accepted matching pushes saturate match_count.
        in_valid = 1'b1; out_ready = 1'b1; o0 = 5'h13; o1 = 5'h00;
        for (int n = 0; n < 300; n++) tick();
        check("sat_match", 32'(match_count), 32'd255);
        check("sat_level", 32'(level),       32'd1);

        // Reset mid-stream.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        check("mid_rst_valid", 32'(out_valid),   32'd0);
        check("mid_rst_level", 32'(level),       32'd0);
        check("mid_rst_data",  32'(out_data),    32'd0);
        check("mid_rst_match", 32'(match_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
